// File: rtl/ss_sg_pkg.sv
// rtl/ss_sg_pkg.sv - shared state encodings and descriptor layout for the scatter-gather engine
package ss_sg_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_D_REQ  = 3'd1,
        S_B_WAIT = 3'd2,
        S_B_REQ  = 3'd3,
        S_NEXT   = 3'd4,
        S_END    = 3'd5,
        S_PANIC  = 3'd6
    } sg_state_e;

    localparam int DESC_LAST_BIT = 20;
    localparam int DESC_LEN_LSB  = 3;

endpackage

// File: rtl/ss_sg2_if.sv
// rtl/ss_sg2_if.sv - Wishbone master bus bundle
interface ss_sg2_if #(
    parameter int AW = 32
);
    logic          wbs_cyc;
    logic          wbs_stb;
    logic          wbs_we;
    logic          wbs_cab;
    logic [3:0]    wbs_sel;
    logic [AW-1:0] wbs_adr;
    logic [31:0]   wbs_dat_o;
    logic [31:0]   wbs_dat64_o;
    logic          wbs_ack;
    logic          wbs_err;
    logic          wbs_rty;

    modport master (
        output wbs_cyc, wbs_stb, wbs_we, wbs_cab, wbs_sel, wbs_adr,
        input  wbs_dat_o, wbs_dat64_o, wbs_ack, wbs_err, wbs_rty
    );

    modport slave (
        input  wbs_cyc, wbs_stb, wbs_we, wbs_cab, wbs_sel, wbs_adr,
        output wbs_dat_o, wbs_dat64_o, wbs_ack, wbs_err, wbs_rty
    );
endinterface

// File: rtl/ss_wb_burst.sv
// rtl/ss_wb_burst.sv - Wishbone burst master: cycle control, address/beat counters, retry counter
module ss_wb_burst #(
    parameter int AW     = 32,
    parameter int BURST  = 16,
    parameter int MAXRTY = 8,
    localparam int CW    = $clog2(BURST) + 1,
    localparam int RW    = $clog2(MAXRTY + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW-4:0] adr_i,
    input  logic          we_i,
    input  logic [CW-1:0] nbeats_i,
    input  logic          stop_i,
    input  logic          kill_i,
    ss_sg2_if.master      wb,
    output logic          beat_o,
    output logic          last_o,
    output logic          err_o,
    output logic          panic_o
);
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-4:0] adr_q, adr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rty_q, rty_d;
    logic          rty_hit;

    // err wins over a simultaneous ack
    assign err_o   = cyc_q & wb.wbs_err;
    assign beat_o  = cyc_q & wb.wbs_ack & ~wb.wbs_err;
    assign rty_hit = cyc_q & wb.wbs_rty & ~wb.wbs_ack & ~wb.wbs_err;
    assign panic_o = rty_hit & (rty_q == RW'(MAXRTY - 1));
    assign last_o  = beat_o & ((cnt_q == CW'(1)) | stop_i);

    always_comb begin
        cyc_d = cyc_q;
        we_d  = we_q;
        adr_d = adr_q;
        cnt_d = cnt_q;
        rty_d = rty_q;
        if (start_i) begin
            cyc_d = 1'b1;
            we_d  = we_i;
            adr_d = adr_i;
            cnt_d = nbeats_i;
            rty_d = '0;
        end else if (cyc_q) begin
            if (beat_o) begin
                adr_d = adr_q + (AW-3)'(1);
                cnt_d = cnt_q - CW'(1);
                rty_d = '0;
            end else if (rty_hit) begin
                rty_d = rty_q + RW'(1);
            end
            if (kill_i || err_o || panic_o || last_o) begin
                cyc_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            cnt_q <= '0;
            rty_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            we_q  <= we_d;
            adr_q <= adr_d;
            cnt_q <= cnt_d;
            rty_q <= rty_d;
        end
    end

    assign wb.wbs_cyc = cyc_q;
    assign wb.wbs_stb = cyc_q;
    assign wb.wbs_cab = cyc_q;
    assign wb.wbs_we  = cyc_q & we_q;
    assign wb.wbs_sel = cyc_q ? 4'hF : 4'h0;
    assign wb.wbs_adr = {adr_q, 3'b000};
endmodule

// File: rtl/ss_sg2.sv
// rtl/ss_sg2.sv - scatter-gather descriptor walker driving buffer bursts over Wishbone
module ss_sg2
    import ss_sg_pkg::*;
#(
    parameter int AW     = 32,
    parameter int LW     = 16,
    parameter int BURST  = 16,
    parameter int MAXRTY = 8,
    localparam int CW    = $clog2(BURST) + 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_rw,
    input  logic [AW-4:0] cmd_desc,
    input  logic          abort,
    ss_sg2_if.master      wb,
    input  logic          ss_start,
    input  logic          ss_stop,
    output logic          ss_xfer,
    output logic          ss_last,
    output logic          done,
    output logic          err,
    output logic [2:0]    err_state,
    output logic [7:0]    sg_state
);
    sg_state_e     state_q, state_d;
    logic          rw_q;
    logic [AW-4:0] next_ptr_q, buf_addr_q;
    logic [LW-1:0] len_q;
    logic          sg_last_q, desc_hi_q;
    logic          err_q;
    logic [2:0]    err_state_q;

    logic          bst_start, bst_we, bst_stop, bst_kill;
    logic [AW-4:0] bst_adr;
    logic [CW-1:0] bst_n, burst_n;
    logic          b_beat, b_last, b_err, b_panic;
    logic          unused_dat;

    assign unused_dat = ^{wb.wbs_dat_o[2:0], wb.wbs_dat64_o[2:0]};
    assign burst_n    = (len_q >= LW'(BURST)) ? CW'(BURST) : len_q[CW-1:0];

    always_comb begin
        state_d   = state_q;
        bst_start = 1'b0;
        bst_adr   = buf_addr_q;
        bst_we    = rw_q;
        bst_n     = burst_n;
        bst_stop  = 1'b0;
        bst_kill  = 1'b0;
        case (state_q)
            S_IDLE:   if (cmd_valid) state_d = S_NEXT;
            S_NEXT: begin
                if (abort || sg_last_q) begin
                    state_d = S_END;
                end else begin
                    state_d   = S_D_REQ;
                    bst_start = 1'b1;
                    bst_adr   = next_ptr_q;
                    bst_we    = 1'b0;
                    bst_n     = CW'(2);
                end
            end
            S_D_REQ: begin
                if (b_err || b_panic) begin
                    state_d = S_PANIC;
                end else if (abort) begin
                    bst_kill = 1'b1;
                    state_d  = S_END;
                end else if (b_last) begin
                    state_d = (len_q == '0) ? S_NEXT : S_B_WAIT;
                end
            end
            S_B_WAIT: begin
                if (abort) begin
                    state_d = S_END;
                end else if (ss_start) begin
                    bst_start = 1'b1;
                    state_d   = S_B_REQ;
                end
            end
            S_B_REQ: begin
                bst_stop = ss_stop | abort;
                if (b_err || b_panic) begin
                    state_d = S_PANIC;
                end else if (b_last) begin
                    // len_q still holds the pre-decrement value on this beat
                    if (abort)                    state_d = S_END;
                    else if (len_q == LW'(1))     state_d = S_NEXT;
                    else                          state_d = S_B_WAIT;
                end
            end
            S_END:   state_d = S_IDLE;
            S_PANIC: state_d = S_PANIC;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            rw_q        <= 1'b0;
            next_ptr_q  <= '0;
            buf_addr_q  <= '0;
            len_q       <= '0;
            sg_last_q   <= 1'b0;
            desc_hi_q   <= 1'b0;
            err_q       <= 1'b0;
            err_state_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && cmd_valid) begin
                rw_q       <= cmd_rw;
                next_ptr_q <= cmd_desc;
                sg_last_q  <= 1'b0;
            end
            if (state_q == S_NEXT) desc_hi_q <= 1'b0;
            if (state_q == S_D_REQ && b_beat) begin
                desc_hi_q <= 1'b1;
                if (!desc_hi_q) begin
                    sg_last_q  <= wb.wbs_dat_o[DESC_LAST_BIT];
                    len_q      <= wb.wbs_dat_o[DESC_LEN_LSB +: LW];
                    buf_addr_q <= wb.wbs_dat64_o[AW-1:3];
                end else begin
                    next_ptr_q <= wb.wbs_dat_o[AW-1:3];
                end
            end
            if (ss_xfer) begin
                buf_addr_q <= buf_addr_q + (AW-3)'(1);
                len_q      <= len_q - LW'(1);
            end
            if (state_d == S_PANIC && state_q != S_PANIC) begin
                err_q       <= 1'b1;
                err_state_q <= state_q;
            end
        end
    end

    ss_wb_burst #(.AW(AW), .BURST(BURST), .MAXRTY(MAXRTY)) u_burst (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .start_i  (bst_start),
        .adr_i    (bst_adr),
        .we_i     (bst_we),
        .nbeats_i (bst_n),
        .stop_i   (bst_stop),
        .kill_i   (bst_kill),
        .wb       (wb),
        .beat_o   (b_beat),
        .last_o   (b_last),
        .err_o    (b_err),
        .panic_o  (b_panic)
    );

    assign cmd_ready = (state_q == S_IDLE);
    assign ss_xfer   = (state_q == S_B_REQ) & b_beat;
    assign ss_last   = ss_xfer & sg_last_q & (len_q == LW'(1));
    assign done      = (state_q == S_END);
    assign err       = err_q;
    assign err_state = err_state_q;
    assign sg_state  = {sg_last_q, 4'h0, state_q};
endmodule

// File: tb/tb_ss_sg2.sv
// tb/tb_ss_sg2.sv - directed bench for ss_sg2 with a zero-wait Wishbone slave model
module tb_ss_sg2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_rw = 1'b0, abort = 1'b0;
    logic [28:0] cmd_desc = '0;
    logic        ss_start = 1'b1, ss_stop = 1'b0;
    logic        cmd_ready, ss_xfer, ss_last, done, err_o;
    logic [2:0]  err_state;
    logic [7:0]  sg_state;

    ss_sg2_if #(.AW(32)) wb ();

    ss_sg2 #(.AW(32), .LW(16), .BURST(16), .MAXRTY(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_desc(cmd_desc), .abort(abort), .wb(wb),
        .ss_start(ss_start), .ss_stop(ss_stop), .ss_xfer(ss_xfer), .ss_last(ss_last),
        .done(done), .err(err_o), .err_state(err_state), .sg_state(sg_state)
    );

    always #5 clk = ~clk;

    int tests_run = 0, tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [31:0] m_lo [0:127];
    logic [31:0] m_hi [0:127];

    int xfer_cnt, last_cnt, last_at, done_cnt, desc_beats, adr_bad, we_bad, cur_burst;
    int rty_left, abort_at, stop_at;
    int bursts[$];
    logic err_desc, exp_we, prev_buf, is_buf, timed_out;
    logic [31:0] exp_adr;

    task automatic set_desc(input int a, input bit last, input int len, input int bufa, input int nxt);
        int i;
        i = (a >> 3) & 127;
        m_lo[i]   = (32'(last) << 20) | (32'(len) << 3);
        m_hi[i]   = 32'(bufa);
        m_lo[i+1] = 32'(nxt);
        m_hi[i+1] = '0;
    endtask

    task automatic clear_stats(input logic [31:0] base, input logic we);
        xfer_cnt = 0; last_cnt = 0; last_at = 0; done_cnt = 0; desc_beats = 0;
        adr_bad = 0; we_bad = 0; cur_burst = 0; bursts.delete();
        rty_left = 0; abort_at = 0; stop_at = 0; err_desc = 1'b0;
        exp_adr = base; exp_we = we; prev_buf = 1'b0;
    endtask

    // slave drives at the falling edge; outputs are sampled 1ns later
    always @(negedge clk) begin
        logic [31:0] a;
        logic        cur_buf;
        a = wb.wbs_adr;
        cur_buf = wb.wbs_cyc && (a >= 32'h1_0000);
        if (prev_buf && !cur_buf) begin
            bursts.push_back(cur_burst);
            cur_burst = 0;
        end
        prev_buf = cur_buf;
        wb.wbs_ack = 1'b0; wb.wbs_err = 1'b0; wb.wbs_rty = 1'b0;
        wb.wbs_dat_o = '0; wb.wbs_dat64_o = '0;
        abort = 1'b0; ss_stop = 1'b0;
        is_buf = a >= 32'h1_0000;
        if (wb.wbs_cyc && wb.wbs_stb) begin
            if (err_desc && !is_buf) begin
                wb.wbs_ack = 1'b1; wb.wbs_err = 1'b1;
            end else if (is_buf && rty_left > 0) begin
                wb.wbs_rty = 1'b1;
                rty_left--;
            end else begin
                wb.wbs_ack = 1'b1;
                if (!is_buf) begin
                    wb.wbs_dat_o   = m_lo[a[9:3]];
                    wb.wbs_dat64_o = m_hi[a[9:3]];
                    desc_beats++;
                end
                if (is_buf && abort_at != 0 && xfer_cnt == abort_at - 1) abort = 1'b1;
                if (is_buf && stop_at != 0 && xfer_cnt == stop_at - 1) ss_stop = 1'b1;
            end
        end
        #1;
        if (ss_xfer) begin
            xfer_cnt++;
            cur_burst++;
            if (wb.wbs_adr !== exp_adr) adr_bad++;
            if (wb.wbs_we !== exp_we) we_bad++;
            exp_adr += 8;
            if (ss_last) begin last_cnt++; last_at = xfer_cnt; end
        end else if (ss_last) begin
            last_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic run(input logic [31:0] d, input logic rw, input int lim);
        int n;
        @(negedge clk);
        cmd_desc = d[31:3]; cmd_rw = rw; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        n = 0;
        while (n < lim && done_cnt == 0 && !err_o) begin
            @(posedge clk);
            n++;
        end
        #1 timed_out = (n >= lim);
    endtask

    initial begin
        clear_stats(32'h1_0000, 1'b0);
        do_reset();
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_cyc", wb.wbs_cyc, 0);
        check("rst_sel", wb.wbs_sel, 0);
        check("rst_err", {err_o, err_state}, 0);
        check("rst_done", done, 0);
        check("rst_state", sg_state, 0);

        // single descriptor, len 5, last
        set_desc(32'h100, 1, 5, 32'h1_0000, 0);
        clear_stats(32'h1_0000, 1'b0);
        run(32'h100, 1'b0, 200);
        check("single_to", timed_out, 0);
        check("single_xfer", xfer_cnt, 5);
        check("single_last_cnt", last_cnt, 1);
        check("single_last_at", last_at, 5);
        check("single_done", done_cnt, 1);
        check("single_adr", adr_bad, 0);
        check("single_we", we_bad, 0);
        check("single_ready", cmd_ready, 1);

        // len 40 split into 16/16/8
        set_desc(32'h100, 1, 40, 32'h2_0000, 0);
        clear_stats(32'h2_0000, 1'b1);
        run(32'h100, 1'b1, 400);
        check("split_to", timed_out, 0);
        check("split_nb", bursts.size(), 3);
        if (bursts.size() == 3) begin
            check("split_b0", bursts[0], 16);
            check("split_b1", bursts[1], 16);
            check("split_b2", bursts[2], 8);
        end
        check("split_adr", adr_bad, 0);
        check("split_we", we_bad, 0);
        check("split_last_at", last_at, 40);

        // three-descriptor chain, middle one empty
        set_desc(32'h100, 0, 3, 32'h1_0000, 32'h200);
        set_desc(32'h200, 0, 0, 32'h3_0000, 32'h300);
        set_desc(32'h300, 1, 4, 32'h4_0000, 0);
        clear_stats(32'h1_0000, 1'b0);
        run(32'h100, 1'b0, 400);
        check("chain_to", timed_out, 0);
        check("chain_xfer", xfer_cnt, 7);
        check("chain_nb", bursts.size(), 2);
        check("chain_desc", desc_beats, 6);
        check("chain_last", last_cnt, 1);
        check("chain_done", done_cnt, 1);

        // ss_stop on beat 2 of 10 -> bursts of 2 and 8
        set_desc(32'h100, 1, 10, 32'h1_0000, 0);
        clear_stats(32'h1_0000, 1'b0);
        stop_at = 2;
        run(32'h100, 1'b0, 400);
        check("stop_nb", bursts.size(), 2);
        if (bursts.size() == 2) begin
            check("stop_b0", bursts[0], 2);
            check("stop_b1", bursts[1], 8);
        end
        check("stop_adr", adr_bad, 0);

        // MAXRTY-1 retries are tolerated
        set_desc(32'h100, 1, 5, 32'h1_0000, 0);
        clear_stats(32'h1_0000, 1'b1);
        rty_left = 3;
        run(32'h100, 1'b1, 200);
        check("rty3_xfer", xfer_cnt, 5);
        check("rty3_err", err_o, 0);
        check("rty3_done", done_cnt, 1);

        // MAXRTY retries panic in S_B_REQ
        clear_stats(32'h1_0000, 1'b1);
        rty_left = 4;
        run(32'h100, 1'b1, 200);
        repeat (2) @(posedge clk);
        #1;
        check("rty4_err", err_o, 1);
        check("rty4_err_state", err_state, 3);
        check("rty4_state", sg_state[2:0], 6);
        check("rty4_cyc", wb.wbs_cyc, 0);
        check("rty4_xfer", xfer_cnt, 0);
        check("rty4_done", done_cnt, 0);

        // ack+err on first descriptor beat -> panic from S_D_REQ
        do_reset();
        clear_stats(32'h1_0000, 1'b0);
        err_desc = 1'b1;
        run(32'h100, 1'b0, 200);
        #1;
        check("derr_err", err_o, 1);
        check("derr_err_state", err_state, 1);
        check("derr_cyc", wb.wbs_cyc, 0);
        check("derr_len", sg_state[7], 0);

        // abort on beat 3 of a 10-beat burst
        do_reset();
        set_desc(32'h100, 1, 10, 32'h1_0000, 0);
        clear_stats(32'h1_0000, 1'b0);
        abort_at = 3;
        run(32'h100, 1'b0, 200);
        check("abort_to", timed_out, 0);
        check("abort_xfer", xfer_cnt, 3);
        check("abort_cyc", wb.wbs_cyc, 0);
        check("abort_done", done_cnt, 1);
        check("abort_ready", cmd_ready, 1);
        check("abort_last", last_cnt, 0);

        // reset in the middle of a burst
        clear_stats(32'h1_0000, 1'b0);
        @(negedge clk);
        cmd_desc = 29'h20; cmd_rw = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int n = 0; n < 100 && xfer_cnt < 4; n++) @(posedge clk);
        check("mid_reached", xfer_cnt >= 4, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_state", sg_state, 0);
        check("mid_cyc", wb.wbs_cyc, 0);
        check("mid_err", err_o, 0);
        check("mid_ready", cmd_ready, 1);
        @(negedge clk); rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ss_sg2.md
SS_SG2 -- requirements
Module: ss_sg2

Interface
REQ-001 Parameter AW, default 32: bus/descriptor address width; addresses are 8-byte aligned, so bits [2:0] are always 0.
REQ-002 Parameter LW, default 16: buffer length counter width, in 8-byte beats.
REQ-003 Parameter BURST, default 16: maximum beats per buffer burst; must be a power of two, 1..256.
REQ-004 Parameter MAXRTY, default 8: consecutive wbs_rty limit before panic.
REQ-005 wb_clk_i  in  1  single clock; all logic rises on it.
REQ-006 wb_rst_i  in  1  reset; synchronous, active-high.
REQ-007 cmd_valid  in  1  start request.
REQ-008 cmd_ready  out  1  block is in S_IDLE.
REQ-009 cmd_rw  in  1  direction (0 = read buffer, 1 = write buffer); captured on accept.
REQ-010 cmd_desc  in  AW-3  first descriptor pointer [AW-1:3].
REQ-011 abort  in  1  stop the chain at the next beat boundary.
REQ-012 wbs_cyc, wbs_stb, wbs_we, wbs_cab  out  1 each  Wishbone master controls.
REQ-013 wbs_sel  out  4  byte select.
REQ-014 wbs_adr  out  AW  beat address; {addr_r, 3'b000}.
REQ-015 wbs_dat_o, wbs_dat64_o  in  32 each  read data, low and high word.
REQ-016 wbs_ack, wbs_err, wbs_rty  in  1 each  Wishbone termination.
REQ-017 ss_start  in  1  data FIFO can accept or supply one burst.
REQ-018 ss_stop  in  1  FIFO requests the burst to end after the current beat.
REQ-019 ss_xfer  out  1  one buffer beat transferred this cycle.
REQ-020 ss_last  out  1  qualifies ss_xfer on the final beat of the chain.
REQ-021 done  out  1  one-cycle pulse when the chain ends.
REQ-022 err  out  1  sticky; set in S_PANIC.
REQ-023 err_state  out  3  state in which the error occurred.
REQ-024 sg_state  out  8  {sg_last, 4'h0, state[2:0]} for debug.

Function
REQ-025 States SHALL be S_IDLE=0, S_D_REQ=1, S_B_WAIT=2, S_B_REQ=3, S_NEXT=4, S_END=5, S_PANIC=6.
REQ-026 S_IDLE: on cmd_valid, capture cmd_rw and cmd_desc, then go to S_NEXT.
REQ-027 S_NEXT:
- if abort or sg_last is set, go to S_END;
- otherwise go to S_D_REQ with a two-beat descriptor read at next_ptr (cyc=stb=cab=1, we=0, sel=4'hF).
REQ-028 First descriptor ack SHALL load:
- sg_last from wbs_dat_o[20];
- len from wbs_dat_o[LW+2:3];
- buf_addr from wbs_dat64_o[AW-1:3].
REQ-029 Second descriptor ack SHALL load next_ptr from wbs_dat_o[AW-1:3] and drop cyc in the same cycle.
REQ-030 After the descriptor read: go to S_B_WAIT if len is nonzero; if len is zero, go to S_NEXT with no bus cycle.
REQ-031 S_B_WAIT: on ss_start, set beat count to min(len, BURST), go to S_B_REQ, and start the burst at buf_addr with we=cmd_rw and sel=4'hF.
REQ-032 S_B_REQ, on each ack (one cycle):
- assert ss_xfer;
- increment buf_addr;
- decrement len and the beat count;
- clear the retry counter.
REQ-033 A burst SHALL end, dropping cyc the same cycle, when the beat count reaches 0 or ss_stop is high on an acking beat.
- After the burst: go to S_NEXT if len is 0, else S_B_WAIT.
REQ-034 ss_last SHALL assert with the ss_xfer of the beat that makes len 0 while sg_last=1.
REQ-035 wbs_rty SHALL increment the retry counter; stb stays high.
- On reaching MAXRTY: err_state=state, go to S_PANIC.
REQ-036 wbs_err in S_D_REQ or S_B_REQ SHALL drop cyc and record err_state; the next state is S_PANIC.
REQ-037 abort seen during S_B_REQ SHALL end the burst after the current acking beat; the next state is S_END.
- abort in S_B_WAIT or S_D_REQ idle-bus cycles goes directly to S_END.
REQ-038 S_END SHALL pulse done for one cycle, then go to S_IDLE.
REQ-039 S_PANIC SHALL hold with cyc=0 until reset.
REQ-040 Simultaneous wbs_ack and wbs_err SHALL be treated as err.
REQ-041 Address increment SHALL wrap modulo 2^(AW-3) with no error.

Reset
REQ-042 wb_rst_i synchronous, active-high, and overriding mid-transfer. Outputs and registers on reset:
- state=S_IDLE;
- wbs_cyc=wbs_stb=wbs_we=wbs_cab=0, wbs_sel=0;
- err=0, err_state=0, done=0;
- sg_last=0, len=0, retry counter=0.

Structure
REQ-043 State encodings and the descriptor bit positions (last=20, len base=3) SHALL live in package ss_sg_pkg.
REQ-044 The Wishbone burst master (cyc/stb/adr counter, retry counter) SHALL be sub-module ss_wb_burst.

Verification
REQ-045 Single descriptor, len=5, last=1, BURST=16, rw=0 -> 5 ss_xfer, ss_last on the 5th, done pulse once.
REQ-046 len=40, BURST=16 -> bursts of 16, 16 and 8 beats, each preceded by ss_start, with buf_addr continuous.
REQ-047 Chain of 3 descriptors, the middle one with len=0 -> no bus cycle for the middle one; total xfers equal the sum of the other two lengths.
REQ-048 MAXRTY=4, 4 consecutive rty in S_B_REQ -> S_PANIC, err=1, err_state=3.
REQ-049 abort on beat 3 of a 10-beat burst -> exactly 3 xfers, cyc drops, done pulse, cmd_ready=1.
REQ-050 wb_rst_i mid-burst -> next cycle state=S_IDLE, cyc=0, err=0.
